siso: RTL and testbench

Parameterised serial-in serial-out shift register. Each rising clock edge captures one bit from `din` into a chain of `DEPTH` flip-flops and shifts the chain one stage toward the output. `out` carries the oldest captured bit, so it is a pure `DEPTH`-cycle delay line. It is used for bit-serial delay alignment and as a building block for serial data paths.

---
 rtl/siso.sv | 72 +++++++
 tb/tb_siso.sv | 135 +++++++++++++
 2 files changed

// File: rtl/siso.sv
// siso: parameterised serial-in serial-out shift register (pure DEPTH-cycle delay line).
//
// Parameters:
//   DEPTH        number of register stages / delay in clock cycles (1..1024)
//   RESET_VALUE  value loaded into every stage on reset
// Ports:
//   clk  in   rising-edge clock; the chain shifts on every edge
//   rst  in   asynchronous active-high reset; forces every stage to RESET_VALUE
//   din  in   serial data in, captured into stage 0
//   out  out  serial data out, driven by the last stage (no path from din)
//
// Optional macro SISO_ASSERT_EN compiles in simulation-only checks: DEPTH
// range at elaboration, X/Z on din while running, and a shadow delay model
// compared against out. Functional behaviour does not depend on it.
module siso #(
    parameter int unsigned DEPTH       = 4,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic out
);

    logic [DEPTH-1:0] stage;

    // A per-bit loop rather than a concatenation keeps DEPTH=1 legal
    // (no stage[DEPTH-2:0] slice).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= {DEPTH{RESET_VALUE}};
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out = stage[DEPTH-1];

`ifdef SISO_ASSERT_EN
    if (DEPTH < 1 || DEPTH > 1024) begin : g_depth_bad
        $error("siso: DEPTH=%0d outside legal range 1..1024", DEPTH);
    end

    // Shadow model: circular history of the last DEPTH inputs. Before each
    // shifting edge, the entry about to be overwritten is the oldest one,
    // which is exactly what out must currently show.
    logic                     hist [DEPTH];
    logic [$clog2(DEPTH+1)-1:0] wp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist[i] <= RESET_VALUE;
            end
            wp <= '0;
        end else begin
            if ($isunknown(din)) begin
                $error("siso: din is X/Z at rising clk edge");
            end
            if (out !== hist[wp]) begin
                $error("siso: out=%b differs from shadow value %b", out, hist[wp]);
            end
            hist[wp] <= din;
            wp       <= (32'(wp) == DEPTH - 1) ? '0 : wp + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_siso.sv
module tb_siso;

    logic clk;
    logic rst;
    logic din;
    logic out4;
    logic out1;
    logic out16;
    logic out4r;

    int checks = 0;
    int errors = 0;

    // Every bit captured since the last reset, oldest first.
    logic hist[$];

    siso #(.DEPTH(4),  .RESET_VALUE(1'b0)) u4   (.clk(clk), .rst(rst), .din(din), .out(out4));
    siso #(.DEPTH(1),  .RESET_VALUE(1'b0)) u1   (.clk(clk), .rst(rst), .din(din), .out(out1));
    siso #(.DEPTH(16), .RESET_VALUE(1'b0)) u16  (.clk(clk), .rst(rst), .din(din), .out(out16));
    siso #(.DEPTH(4),  .RESET_VALUE(1'b1)) u4r  (.clk(clk), .rst(rst), .din(din), .out(out4r));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay-line rule: out shows the bit captured DEPTH edges ago, or the
    // reset value while fewer than DEPTH bits have entered since reset.
    function automatic logic model(input int d, input logic rv);
        if (hist.size() >= d) return hist[hist.size() - d];
        return rv;
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_d4"},   out4,  model(4, 1'b0));
        chk({tag, "_d1"},   out1,  model(1, 1'b0));
        chk({tag, "_d16"},  out16, model(16, 1'b0));
        chk({tag, "_d4rv"}, out4r, model(4, 1'b1));
    endtask

    // Drive din, let one rising edge happen, then sample 1 unit later.
    task automatic step(input logic b, input string tag);
        din = b;
        @(posedge clk);
        if (!rst) hist.push_back(b);
        #1;
        check_all(tag);
    endtask

    // Called just after a sampling point: asserts reset between edges,
    // checks the asynchronous effect, holds across one edge, then releases.
    task automatic do_reset(input string tag);
        #3;
        rst = 1'b1;
        hist.delete();
        #1;
        check_all({tag, "_async"});
        chk({tag, "_async_lit0"}, out4, 1'b0);
        chk({tag, "_async_lit1"}, out4r, 1'b1);
        step(~din, {tag, "_hold"});
        rst = 1'b0;
    endtask

    logic pulse_exp [6];
    logic pat_in    [8];
    logic pat_exp   [8];

    initial begin
        pulse_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        pat_in    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pat_exp   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b0;
        din = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_all("por");

        // Clock running, din toggling, reset held: nothing shifts.
        for (int i = 0; i < 6; i++) step(logic'(i % 2 == 0), "rst_held");
        rst = 1'b0;

        // Single pulse.
        step(1'b1, "pulse");
        chk("pulse_lit_0", out4, pulse_exp[0]);
        for (int i = 1; i < 6; i++) begin
            step(1'b0, "pulse");
            chk("pulse_lit", out4, pulse_exp[i]);
        end

        // 1,0,1,0 pattern from an empty chain.
        do_reset("pre_pat");
        for (int i = 0; i < 8; i++) begin
            step(pat_in[i], "pattern");
            chk("pattern_lit", out4, pat_exp[i]);
        end

        // Fill with ones, then reset mid-stream between edges.
        for (int i = 0; i < 16; i++) step(1'b1, "ones");
        chk("ones_full_d4", out4, 1'b1);
        do_reset("mid");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, "refill");
            chk("refill_lit", out4, 1'b0);
        end
        step(1'b1, "refill_last");
        chk("refill_lit_last", out4, 1'b1);

        // RESET_VALUE=1 instance: din=0 after release.
        do_reset("rv");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, "rv_zero");
            chk("rv_lit_hold", out4r, 1'b1);
        end
        step(1'b0, "rv_zero_last");
        chk("rv_lit_drop", out4r, 1'b0);

        // Random streams.
        do_reset("pre_rand");
        for (int i = 0; i < 64; i++) step(logic'($urandom_range(0, 1)), "rand64");
        do_reset("pre_rand2");
        for (int i = 0; i < 40; i++) step(logic'($urandom_range(0, 1)), "rand40");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
